// File: rtl/uart_rx_param.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : uart_rx_param
//  Purpose  : Parametrised UART receiver. 2-flop input synchroniser,
//             3-sample majority vote around mid-bit, false-start rejection,
//             parity / framing / break detection, and a one-entry holding
//             register presented on a valid/ready stream with overrun pulse.
//  Ports    : clk           - system clock (rising edge)
//             sreset        - synchronous reset, active-high
//             serial_in     - asynchronous RX line, idle high
//             m_valid       - holding register contains a frame
//             m_ready       - consumer accepts frame when m_valid && m_ready
//             m_data        - received data word (LSB first on the line)
//             m_parity_err  - parity mismatch for the held frame
//             m_frame_err   - a stop-bit vote was 0
//             m_break       - every data/parity/stop vote was 0
//             overrun       - 1-cycle pulse: frame completed while full,
//                             that frame was dropped
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx_param #(
   parameter int CLK_FREQ  = 12000000,
   parameter int BAUD_RATE = 115200,
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic                 clk,
   input  logic                 sreset,
   input  logic                 serial_in,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic [DATA_BITS-1:0] m_data,
   output logic                 m_parity_err,
   output logic                 m_frame_err,
   output logic                 m_break,
   output logic                 overrun
);

   localparam int CPB = CLK_FREQ / BAUD_RATE;
   localparam int CW  = $clog2(CPB);
   localparam int MID = CPB / 2;
   localparam int BW  = $clog2(DATA_BITS + 1);

   localparam logic [CW-1:0] C_BAUD_LAST = CW'(CPB - 1);
   localparam logic [CW-1:0] C_SAMP_A    = CW'(MID - 1);
   localparam logic [CW-1:0] C_SAMP_B    = CW'(MID);
   localparam logic [CW-1:0] C_VOTE      = CW'(MID + 1);
   localparam logic [BW-1:0] C_DATA_LAST = BW'(DATA_BITS - 1);
   localparam logic [BW-1:0] C_STOP_LAST = BW'(STOP_BITS - 1);
   // Required value of XOR(data, parity bit): 1 for odd, 0 for even
   localparam logic          C_PAR_WANT  = (PARITY == 1) ? 1'b1 : 1'b0;

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_START      = 3'd1,
      S_DATA       = 3'd2,
      S_PARITY     = 3'd3,
      S_STOP       = 3'd4,
      S_BREAK_WAIT = 3'd5
   } state_t;

   state_t               state_q, state_d;
   logic [1:0]           sync_q, sync_d;
   logic [CW-1:0]        baud_q, baud_d;
   logic [BW-1:0]        bit_q, bit_d;
   logic [1:0]           samp_q, samp_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 par_err_q, par_err_d;
   logic                 frm_err_q, frm_err_d;
   logic                 zero_q, zero_d;
   logic                 m_valid_q, m_valid_d;
   logic [DATA_BITS-1:0] m_data_q, m_data_d;
   logic                 m_perr_q, m_perr_d;
   logic                 m_ferr_q, m_ferr_d;
   logic                 m_brk_q, m_brk_d;
   logic                 overrun_q, overrun_d;

   logic rx;
   logic at_wrap;
   logic at_vote;
   logic vote;

   assign rx      = sync_q[1];
   assign at_wrap = (baud_q == C_BAUD_LAST);
   assign at_vote = (baud_q == C_VOTE);
   // Two earlier samples are held in samp_q; the third is the live rx
   assign vote    = (samp_q[1] & samp_q[0]) | (samp_q[1] & rx) | (samp_q[0] & rx);

   always_comb begin
      logic done;
      logic fin_ferr;
      logic fin_brk;

      state_d   = state_q;
      sync_d    = {sync_q[0], serial_in};
      baud_d    = baud_q;
      bit_d     = bit_q;
      samp_d    = samp_q;
      data_d    = data_q;
      par_err_d = par_err_q;
      frm_err_d = frm_err_q;
      zero_d    = zero_q;
      m_valid_d = m_valid_q;
      m_data_d  = m_data_q;
      m_perr_d  = m_perr_q;
      m_ferr_d  = m_ferr_q;
      m_brk_d   = m_brk_q;
      overrun_d = 1'b0;
      done      = 1'b0;
      fin_ferr  = frm_err_q | ~vote;
      fin_brk   = zero_q & ~vote;

      // Bit-timing counter and pre-vote sample shift run in all in-frame states
      if (state_q != S_IDLE && state_q != S_BREAK_WAIT) begin
         baud_d = at_wrap ? '0 : baud_q + CW'(1);
         if (baud_q == C_SAMP_A || baud_q == C_SAMP_B) begin
            samp_d = {samp_q[0], rx};
         end
      end

      case (state_q)
         S_IDLE: begin
            baud_d    = '0;
            bit_d     = '0;
            par_err_d = 1'b0;
            frm_err_d = 1'b0;
            zero_d    = 1'b1;
            if (!rx) begin
               state_d = S_START;
            end
         end
         S_START: begin
            if (at_vote && vote) begin
               // Line back high by mid-bit: noise, not a start bit
               state_d = S_IDLE;
               baud_d  = '0;
            end else if (at_wrap) begin
               state_d = S_DATA;
               bit_d   = '0;
            end
         end
         S_DATA: begin
            if (at_vote) begin
               zero_d = zero_q & ~vote;
               for (int i = 0; i < DATA_BITS; i++) begin
                  if (bit_q == BW'(i)) begin
                     data_d[i] = vote;
                  end
               end
            end
            if (at_wrap) begin
               if (bit_q == C_DATA_LAST) begin
                  bit_d   = '0;
                  state_d = (PARITY != 0) ? S_PARITY : S_STOP;
               end else begin
                  bit_d = bit_q + BW'(1);
               end
            end
         end
         S_PARITY: begin
            if (at_vote) begin
               zero_d = zero_q & ~vote;
               if (((^data_q) ^ vote) != C_PAR_WANT) begin
                  par_err_d = 1'b1;
               end
            end
            if (at_wrap) begin
               state_d = S_STOP;
               bit_d   = '0;
            end
         end
         S_STOP: begin
            if (at_vote) begin
               if (bit_q == C_STOP_LAST) begin
                  // Frame ends at the final stop vote; the rest of the bit is not waited for
                  done    = 1'b1;
                  baud_d  = '0;
                  state_d = vote ? S_IDLE : S_BREAK_WAIT;
               end else begin
                  frm_err_d = fin_ferr;
                  zero_d    = fin_brk;
               end
            end else if (at_wrap) begin
               bit_d = bit_q + BW'(1);
            end
         end
         S_BREAK_WAIT: begin
            // Start detection suppressed until the line idles high again
            baud_d = '0;
            if (rx) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
            baud_d  = '0;
         end
      endcase

      // One-entry holding register with back-pressure
      if (done) begin
         if (!m_valid_q || m_ready) begin
            m_valid_d = 1'b1;
            m_data_d  = data_q;
            m_perr_d  = par_err_q;
            m_ferr_d  = fin_ferr;
            m_brk_d   = fin_brk;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (m_valid_q && m_ready) begin
         m_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (sreset) begin
         state_q   <= S_IDLE;
         sync_q    <= 2'b11;
         baud_q    <= '0;
         bit_q     <= '0;
         samp_q    <= '0;
         data_q    <= '0;
         par_err_q <= 1'b0;
         frm_err_q <= 1'b0;
         zero_q    <= 1'b0;
         m_valid_q <= 1'b0;
         m_data_q  <= '0;
         m_perr_q  <= 1'b0;
         m_ferr_q  <= 1'b0;
         m_brk_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         sync_q    <= sync_d;
         baud_q    <= baud_d;
         bit_q     <= bit_d;
         samp_q    <= samp_d;
         data_q    <= data_d;
         par_err_q <= par_err_d;
         frm_err_q <= frm_err_d;
         zero_q    <= zero_d;
         m_valid_q <= m_valid_d;
         m_data_q  <= m_data_d;
         m_perr_q  <= m_perr_d;
         m_ferr_q  <= m_ferr_d;
         m_brk_q   <= m_brk_d;
         overrun_q <= overrun_d;
      end
   end

   assign m_valid      = m_valid_q;
   assign m_data       = m_data_q;
   assign m_parity_err = m_perr_q;
   assign m_frame_err  = m_ferr_q;
   assign m_break      = m_brk_q;
   assign overrun      = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_param.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx_param
//  Purpose  : Self-checking bench for uart_rx_param. Four instances
//             (8N1, 8E1, 8O1, 9N2) at 12 clk/bit share clock and reset.
//             A frame-level model predicts, from the bits sent and the frame
//             latency, each instance's holding register and overrun pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_param;

   localparam int CPB = 12;
   localparam int MID = CPB / 2;

   logic       clk = 1'b0;
   logic       sreset;
   logic [3:0] ser;
   logic [3:0] rdy;
   logic [3:0] vld, perr, ferr, brk, ovr;
   logic [7:0] d0, d1, d2;
   logic [8:0] d3;
   logic [8:0] dat [4];

   always #5 clk = ~clk;

   assign dat[0] = {1'b0, d0};
   assign dat[1] = {1'b0, d1};
   assign dat[2] = {1'b0, d2};
   assign dat[3] = d3;

   uart_rx_param #(.CLK_FREQ(12000000), .BAUD_RATE(1000000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_n81 (
      .clk(clk), .sreset(sreset), .serial_in(ser[0]), .m_valid(vld[0]), .m_ready(rdy[0]), .m_data(d0),
      .m_parity_err(perr[0]), .m_frame_err(ferr[0]), .m_break(brk[0]), .overrun(ovr[0]));
   uart_rx_param #(.CLK_FREQ(12000000), .BAUD_RATE(1000000), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_e81 (
      .clk(clk), .sreset(sreset), .serial_in(ser[1]), .m_valid(vld[1]), .m_ready(rdy[1]), .m_data(d1),
      .m_parity_err(perr[1]), .m_frame_err(ferr[1]), .m_break(brk[1]), .overrun(ovr[1]));
   uart_rx_param #(.CLK_FREQ(12000000), .BAUD_RATE(1000000), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_o81 (
      .clk(clk), .sreset(sreset), .serial_in(ser[2]), .m_valid(vld[2]), .m_ready(rdy[2]), .m_data(d2),
      .m_parity_err(perr[2]), .m_frame_err(ferr[2]), .m_break(brk[2]), .overrun(ovr[2]));
   uart_rx_param #(.CLK_FREQ(12000000), .BAUD_RATE(1000000), .DATA_BITS(9), .PARITY(0), .STOP_BITS(2)) u_n92 (
      .clk(clk), .sreset(sreset), .serial_in(ser[3]), .m_valid(vld[3]), .m_ready(rdy[3]), .m_data(d3),
      .m_parity_err(perr[3]), .m_frame_err(ferr[3]), .m_break(brk[3]), .overrun(ovr[3]));

   function automatic int cfg_d(input int i);
      return (i == 3) ? 9 : 8;
   endfunction
   function automatic int cfg_p(input int i);
      return (i == 1) ? 2 : (i == 2) ? 1 : 0;
   endfunction
   function automatic int cfg_s(input int i);
      return (i == 3) ? 2 : 1;
   endfunction

   typedef struct {
      int         inst;
      int         edge_n;
      logic [8:0] data;
      logic       pe;
      logic       fe;
      logic       br;
   } exp_t;

   exp_t       pend[$];
   int         edge_no = 0;
   int         errors  = 0;
   int         checks  = 0;
   bit         run_cmp = 1'b0;

   bit         mv   [4];
   logic [8:0] md   [4];
   logic       mpe  [4];
   logic       mfe  [4];
   logic       mbr  [4];
   logic       movr [4];

   int         acc_cnt   [4];
   int         ovr_cnt   [4];
   int         rise_edge [4];
   logic [8:0] acc_data  [4];
   logic       acc_pe    [4];
   logic       acc_fe    [4];
   logic       acc_br    [4];
   logic       prev_v    [4];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Expected frame outcome from the bits placed on the line
   function automatic exp_t make_exp(input int i, input logic [8:0] data, input logic pbit,
                                     input logic [1:0] stops, input int fall_edge);
      exp_t e;
      int   nd = cfg_d(i);
      int   np = cfg_p(i);
      int   ns = cfg_s(i);
      int   pb = (np != 0) ? 1 : 0;
      logic [8:0] m = '0;
      for (int b = 0; b < nd; b++) m[b] = data[b];
      e.inst   = i;
      e.data   = m;
      e.pe     = (np == 0) ? 1'b0 : (((^m) ^ pbit) != ((np == 1) ? 1'b1 : 1'b0));
      e.fe     = !stops[0] || (ns == 2 && !stops[1]);
      e.br     = (m == 9'd0) && (np == 0 || !pbit) && !stops[0] && (ns == 1 || !stops[1]);
      // sync (2) + all bits before the final stop + vote offset (MID+1) + load edge
      e.edge_n = fall_edge + 2 + CPB * (nd + pb + ns) + MID + 2;
      return e;
   endfunction

   // Model of the holding register, advanced on every clock edge
   always @(posedge clk) begin
      bit   dn [4];
      exp_t de [4];
      int   k;
      edge_no = edge_no + 1;
      for (int i = 0; i < 4; i++) begin
         dn[i] = 1'b0;
         if (run_cmp && vld[i] && rdy[i]) begin
            acc_cnt[i]++;
            acc_data[i] = dat[i];
            acc_pe[i]   = perr[i];
            acc_fe[i]   = ferr[i];
            acc_br[i]   = brk[i];
         end
      end
      if (sreset) begin
         pend.delete();
         for (int i = 0; i < 4; i++) begin
            mv[i] = 1'b0; md[i] = '0; mpe[i] = 1'b0; mfe[i] = 1'b0; mbr[i] = 1'b0; movr[i] = 1'b0;
         end
      end else begin
         k = 0;
         while (k < pend.size()) begin
            if (pend[k].edge_n == edge_no) begin
               dn[pend[k].inst] = 1'b1;
               de[pend[k].inst] = pend[k];
               pend.delete(k);
            end else begin
               k++;
            end
         end
         for (int i = 0; i < 4; i++) begin
            movr[i] = 1'b0;
            if (dn[i]) begin
               if (!mv[i] || rdy[i]) begin
                  mv[i] = 1'b1; md[i] = de[i].data; mpe[i] = de[i].pe; mfe[i] = de[i].fe; mbr[i] = de[i].br;
               end else begin
                  movr[i] = 1'b1;
               end
            end else if (mv[i] && rdy[i]) begin
               mv[i] = 1'b0;
            end
         end
      end
   end

   // Compare DUT against model away from the active edge
   always @(negedge clk) begin
      if (run_cmp) begin
         for (int i = 0; i < 4; i++) begin
            chk($sformatf("inst%0d valid", i), {31'd0, vld[i]}, {31'd0, mv[i]});
            chk($sformatf("inst%0d overrun", i), {31'd0, ovr[i]}, {31'd0, movr[i]});
            if (mv[i]) begin
               chk($sformatf("inst%0d data", i), {23'd0, dat[i]}, {23'd0, md[i]});
               chk($sformatf("inst%0d parity_err", i), {31'd0, perr[i]}, {31'd0, mpe[i]});
               chk($sformatf("inst%0d frame_err", i), {31'd0, ferr[i]}, {31'd0, mfe[i]});
               chk($sformatf("inst%0d break", i), {31'd0, brk[i]}, {31'd0, mbr[i]});
            end
            if (ovr[i]) ovr_cnt[i]++;
            if (vld[i] && !prev_v[i]) rise_edge[i] = edge_no;
            prev_v[i] = vld[i];
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive_bit(input int i, input logic b);
      ser[i] = b;
      idle(CPB);
   endtask

   task automatic send(input int i, input logic [8:0] data, input logic pbit,
                       input logic [1:0] stops, output int fall_edge);
      fall_edge = edge_no + 1;
      pend.push_back(make_exp(i, data, pbit, stops, fall_edge));
      drive_bit(i, 1'b0);
      for (int b = 0; b < cfg_d(i); b++) drive_bit(i, data[b]);
      if (cfg_p(i) != 0) drive_bit(i, pbit);
      for (int s = 0; s < cfg_s(i); s++) drive_bit(i, stops[s]);
      ser[i] = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int f;
      int c0;
      int o0;
      for (int i = 0; i < 4; i++) begin
         acc_cnt[i] = 0; ovr_cnt[i] = 0; rise_edge[i] = 0; prev_v[i] = 1'b0;
         mv[i] = 1'b0; md[i] = '0; mpe[i] = 1'b0; mfe[i] = 1'b0; mbr[i] = 1'b0; movr[i] = 1'b0;
      end
      sreset = 1'b1;
      ser    = 4'hF;
      rdy    = 4'hF;
      @(posedge clk);
      #1;
      run_cmp = 1'b1;
      idle(2);
      sreset = 1'b0;
      chk("reset valid", {31'd0, vld[0]}, 32'd0);
      chk("reset data", {24'd0, d0}, 32'd0);
      chk("reset flags", {28'd0, perr[0], ferr[0], brk[0], ovr[0]}, 32'd0);
      idle(CPB);

      // 8N1 0xA5, latency pinned to the hand-computed 118 cycles
      send(0, 9'h0A5, 1'b0, 2'b11, f);
      idle(2 * CPB);
      chk("t1 count", acc_cnt[0], 32'd1);
      chk("t1 data", {23'd0, acc_data[0]}, 32'hA5);
      chk("t1 flags", {29'd0, acc_pe[0], acc_fe[0], acc_br[0]}, 32'd0);
      chk("t1 latency", rise_edge[0] - f, 32'd118);

      // Even parity: 0x03 has even ones, so parity bit 1 is wrong
      send(1, 9'h003, 1'b1, 2'b11, f);
      idle(2 * CPB);
      chk("t2 even bad perr", {31'd0, acc_pe[1]}, 32'd1);
      chk("t2 even bad data", {23'd0, acc_data[1]}, 32'h03);
      send(1, 9'h003, 1'b0, 2'b11, f);
      idle(2 * CPB);
      chk("t2 even good perr", {31'd0, acc_pe[1]}, 32'd0);
      // Odd parity: 0x03 needs parity bit 1
      send(2, 9'h003, 1'b0, 2'b11, f);
      idle(2 * CPB);
      chk("t2 odd bad perr", {31'd0, acc_pe[2]}, 32'd1);
      send(2, 9'h003, 1'b1, 2'b11, f);
      idle(2 * CPB);
      chk("t2 odd good perr", {31'd0, acc_pe[2]}, 32'd0);
      chk("t2 count", acc_cnt[1] + acc_cnt[2], 32'd4);

      // 3-cycle glitch must be rejected, then a good frame
      c0 = acc_cnt[0];
      ser[0] = 1'b0;
      idle(3);
      ser[0] = 1'b1;
      idle(3 * CPB);
      chk("t3 glitch no frame", acc_cnt[0] - c0, 32'd0);
      send(0, 9'h05A, 1'b0, 2'b11, f);
      idle(2 * CPB);
      chk("t3 data", {23'd0, acc_data[0]}, 32'h5A);

      // Back-pressure: second frame dropped with one overrun pulse
      rdy[0] = 1'b0;
      c0 = acc_cnt[0];
      o0 = ovr_cnt[0];
      send(0, 9'h011, 1'b0, 2'b11, f);
      send(0, 9'h022, 1'b0, 2'b11, f);
      idle(CPB);
      chk("t4 overrun pulses", ovr_cnt[0] - o0, 32'd1);
      chk("t4 held data", {24'd0, d0}, 32'h11);
      chk("t4 held valid", {31'd0, vld[0]}, 32'd1);
      rdy[0] = 1'b1;
      idle(2);
      chk("t4 accepted data", {23'd0, acc_data[0]}, 32'h11);
      chk("t4 accepted count", acc_cnt[0] - c0, 32'd1);
      chk("t4 valid dropped", {31'd0, vld[0]}, 32'd0);

      // Break: line low for 30 bit times yields exactly one frame
      c0 = acc_cnt[0];
      f = edge_no + 1;
      pend.push_back(make_exp(0, 9'h000, 1'b0, 2'b00, f));
      ser[0] = 1'b0;
      idle(30 * CPB);
      ser[0] = 1'b1;
      idle(3 * CPB);
      chk("t5 one frame", acc_cnt[0] - c0, 32'd1);
      chk("t5 data", {23'd0, acc_data[0]}, 32'h00);
      chk("t5 break/frame_err", {30'd0, acc_br[0], acc_fe[0]}, 32'd3);
      send(0, 9'h07E, 1'b0, 2'b11, f);
      idle(2 * CPB);
      chk("t5 next data", {23'd0, acc_data[0]}, 32'h7E);
      chk("t5 next flags", {29'd0, acc_pe[0], acc_fe[0], acc_br[0]}, 32'd0);

      // 9N2 with bad second stop bit
      send(3, 9'h1FF, 1'b0, 2'b01, f);
      idle(2 * CPB);
      chk("t6 data", {23'd0, acc_data[3]}, 32'h1FF);
      chk("t6 frame_err", {31'd0, acc_fe[3]}, 32'd1);
      chk("t6 break", {31'd0, acc_br[3]}, 32'd0);
      // Reset in the middle of a frame abandons it
      c0 = acc_cnt[3];
      ser[3] = 1'b0;
      idle(CPB);
      ser[3] = 1'b1;
      idle(CPB);
      ser[3] = 1'b0;
      idle(MID);
      sreset = 1'b1;
      idle(2);
      sreset = 1'b0;
      ser[3] = 1'b1;
      idle(14 * CPB);
      chk("t6 reset no frame", acc_cnt[3] - c0, 32'd0);
      chk("t6 reset valid", {31'd0, vld[3]}, 32'd0);
      send(3, 9'h0A5, 1'b0, 2'b11, f);
      idle(2 * CPB);
      chk("t6 after reset data", {23'd0, acc_data[3]}, 32'h0A5);
      chk("t6 after reset count", acc_cnt[3] - c0, 32'd1);
      chk("t6 after reset flags", {29'd0, acc_pe[3], acc_fe[3], acc_br[3]}, 32'd0);

      chk("no undelivered frames", pend.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receiver, the successor to the basic 8N1 receiver used in the loopback test.
- Configurable data width, parity mode and stop-bit count.
- 3-sample majority vote at mid-bit; false-start rejection.
- Framing, parity, break and overrun reporting.
- Delivers each byte/word on a valid/ready stream with a one-entry holding register, so downstream logic (loopback, FIFOs) can apply back-pressure.

Parameters:
CLK_FREQ, 12000000, system clock frequency in Hz
BAUD_RATE, 115200, line rate in bit/s; CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (integer divide), must be >= 8
DATA_BITS, 8, data bits per frame, legal range 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2

Ports:
clk  input  1  system clock, all logic on rising edge
sreset  input  1  synchronous reset, active-high
serial_in  input  1  asynchronous RX line, idle high
m_valid  output  1  holding register contains a frame
m_ready  input  1  consumer accepts frame when m_valid && m_ready
m_data  output  DATA_BITS  received data, LSB first on the line
m_parity_err  output  1  parity mismatch for this frame (0 when PARITY=0)
m_frame_err  output  1  any stop-bit sample was 0
m_break  output  1  all data, parity and stop samples were 0
overrun  output  1  one-cycle pulse: a frame completed while the holding register was full; that new frame is dropped

Behaviour:
Reset:
- sreset has priority over all other logic.
- Reset values: state IDLE, all counters 0, m_valid=0, m_data=0, all error flags 0, overrun=0.
- Reset mid-frame abandons the frame with no output.
- Both synchroniser flops reset to 1.

Input sampling:
- serial_in passes through a 2-flop synchroniser; rx denotes the synchroniser output.
- baud_ctr is $clog2(CLKS_PER_BIT) bits wide and counts 0..CLKS_PER_BIT-1, then wraps to 0 and advances bit_ctr.
- Mid-bit sample M = CLKS_PER_BIT/2.
- Bit value = majority of rx at baud_ctr = M-1, M and M+1. Samples are taken as registered shifts; the vote resolves at M+1.

State machine:
- IDLE: baud_ctr held at 0. On rx==0 go to START; the next cycle is baud_ctr=0.
- START: at vote, if the bit is 1 treat it as a glitch and return to IDLE with no flags. If 0, continue; at wrap go to DATA with bit_ctr=0.
- DATA: the vote value shifts into the data register at index bit_ctr. At wrap, bit_ctr increments. After DATA_BITS bits go to PARITY if PARITY!=0, else STOP.
- PARITY: the vote is compared with the computed parity. Odd: the XOR of data and parity bit must be 1. Even: it must be 0. A mismatch sets the pending parity_err.
- STOP: vote for each stop bit; any 0 sets the pending frame_err.
  - At the vote of the final stop bit the frame is complete; there is no wait for the remainder of that bit.
  - The next state is IDLE if the final stop sample was 1, else BREAK_WAIT.
- BREAK_WAIT: stays until rx==1, then IDLE. No start detection happens in this state, so a held-low line yields exactly one frame.
- Break: pending break = every data, parity and stop vote was 0. frame_err is also 1 for a break.

Output handshake:
- Frame complete with m_valid==0, or with m_valid && m_ready in the same cycle: m_data and the flags load on the next edge and m_valid=1.
- Frame complete with m_valid && !m_ready: overrun=1 for one cycle and the held frame is unchanged.
- m_valid && m_ready with no new frame: m_valid clears next edge.
- m_data and the flags stay stable while m_valid && !m_ready.

Timing:
- Back-to-back frames: a start edge is accepted from the cycle after the final stop vote.
- Latency: m_valid rises 1 cycle after the final stop-bit vote.

Test Plan:
1. CLK_FREQ=12e6, BAUD=1e6 (12 clk/bit), 8N1, send 0xA5 with m_ready=1 -> one m_valid pulse, m_data=0xA5, all flags 0. m_valid rises 2+12*9+7+1 cycles after the serial_in falling edge, within ±1.
2. 8E1: send 0x03 with parity bit 1 -> m_parity_err=1, m_data=0x03. Resend with parity bit 0 -> m_parity_err=0. Repeat for 8O1 with the inverse parity bit.
3. Low glitch of 3 clk on idle line -> no m_valid, state returns to IDLE. Then a valid 0x5A frame -> m_data=0x5A.
4. m_ready=0, send 0x11 then 0x22 back-to-back -> m_data remains 0x11 and overrun pulses once at the 0x22 stop vote. Raise m_ready -> 0x11 accepted, m_valid drops.
5. Hold serial_in low for 30 bit times, then high -> exactly one frame: m_data=0, m_break=1, m_frame_err=1. Next valid 0x7E frame is received correctly.
6. DATA_BITS=9, STOP_BITS=2: send 0x1FF with second stop bit 0 -> m_frame_err=1. Assert sreset mid-frame -> no m_valid; the following frame is received correctly.
